uart_rx_oversampled: RTL and testbench

//   UART serial receiver for asynchronous 8N1-style frames. It consumes the
//   16x-oversampling tick from the baud-rate generator, which feeds s_tick.

---
 rtl/uart_rx_oversampled.sv | 132 +++++++++++++
 tb/tb_uart_rx_oversampled.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// UART 8N1-style receiver driven by a 16x oversampling tick.
// Samples each bit at mid-point, LSB first, flags a low stop bit.
module uart_rx_oversampled #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   s_q;
    logic [SW-1:0]   s_d;
    logic [NW-1:0]   n_q;
    logic [NW-1:0]   n_d;
    logic [DBIT-1:0] sh_q;
    logic [DBIT-1:0] sh_d;
    logic [DBIT-1:0] dout_d;
    logic            ferr_d;
    logic            done_d;
    logic            rx_meta;
    logic            rx_s;

    // Idle-high line, so both sync stages reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            sh_q         <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            sh_q         <= sh_d;
            dout         <= dout_d;
            frame_err    <= ferr_d;
            rx_done_tick <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        dout_d  = dout;
        ferr_d  = frame_err;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d  = '0;
                        sh_d = {rx_s, sh_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        dout_d  = sh_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed table,
// multi-cycle corner sequences and random frames vs. a frame model.
module tb_uart_rx_oversampled;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int tick_cnt = 0;
    logic tick_en;
    logic [7:0] exp_last;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         mode;
        int         gap;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .s_tick      (s_tick),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = tick_en && (tick_cnt == 0);
            tick_cnt = (tick_cnt == DIV - 1) ? 0 : tick_cnt + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_done_tick === 1'b1) begin
                got_q.push_back({frame_err, dout});
                done_cnt++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (s_tick !== 1'b1);
        #1;
    endtask

    task automatic line(input logic v, input int ticks);
        rx = v;
        repeat (ticks) wait_tick();
    endtask

    // mode 1: normal stop; 0: stop low 12 ticks then high; 2: break
    task automatic send_frame(input logic [7:0] d, input int mode);
        wait_tick();
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) line(d[i], 16);
        if (mode == 1) begin
            line(1'b1, 16);
        end else if (mode == 0) begin
            line(1'b0, 12);
            line(1'b1, 20);
        end else begin
            line(1'b0, 16);
        end
    endtask

    // Model of one frame on the wire: data word and stop-bit level.
    function automatic logic [8:0] model(input logic [7:0] d,
                                         input int mode);
        logic [9:0] wire_bits;
        logic [7:0] w;
        wire_bits = {(mode == 1), d, 1'b0};
        for (int i = 0; i < 8; i++) w[i] = wire_bits[i + 1];
        return {~wire_bits[9], w};
    endfunction

    task automatic check_frames(input string name);
        int n;
        chk({name, "_ndone"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_dout"}, got_q[i][7:0], exp_q[i][7:0]);
            chk({name, "_ferr"}, got_q[i][8], exp_q[i][8]);
        end
        if (exp_q.size() > 0) exp_last = exp_q[exp_q.size() - 1][7:0];
        chk({name, "_hold"}, dout, exp_last);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base;
        logic [7:0] d;
        int m;

        vecs[0] = '{8'hA5, 1, 16, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 0, 0, 8'h3C, 1'b1};
        vecs[2] = '{8'h00, 1, 0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1, 16, 8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1, 0, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 1, 16, 8'h80, 1'b0};

        reset = 1'b1;
        rx = 1'b1;
        tick_en = 1'b1;
        exp_last = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", rx_done_tick, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        reset = 1'b0;
        repeat (20) wait_tick();

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({vecs[i].exp_ferr, vecs[i].exp_dout});
            send_frame(vecs[i].data, vecs[i].mode);
            line(1'b1, vecs[i].gap);
        end
        line(1'b1, 32);
        check_frames("table");

        wait_tick();
        line(1'b0, 3);
        line(1'b1, 40);
        check_frames("glitch");

        base = done_cnt;
        exp_q.push_back({1'b1, 8'h96});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h96, 2);
        for (int i = 0; i < 4000 && done_cnt < base + 3; i++)
            @(negedge clk);
        chk("break_wait", done_cnt - base, 3);
        rx = 1'b1;
        line(1'b1, 40);
        check_frames("break");

        fork
            send_frame(8'h81, 1);
            begin
                repeat (16 * 5 + 8) wait_tick();
                reset = 1'b1;
                repeat (16 * 5) wait_tick();
                reset = 1'b0;
            end
        join
        line(1'b1, 32);
        exp_last = 8'h00;
        check_frames("rst_mid");
        chk("rst_mid_ferr", frame_err, 1'b0);

        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1);
        line(1'b1, 32);
        check_frames("after_rst");

        exp_q.push_back({1'b0, 8'hC3});
        fork
            send_frame(8'hC3, 1);
            begin
                repeat (16 * 4 + 8) wait_tick();
                tick_en = 1'b0;
                base = done_cnt;
                repeat (1000) @(posedge clk);
                chk("stall_no_done", done_cnt, base);
                tick_en = 1'b1;
            end
        join
        line(1'b1, 32);
        check_frames("stall");

        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 0 : 1;
            exp_q.push_back(model(d, m));
            send_frame(d, m);
            line(1'b1, $urandom_range(0, 20));
        end
        line(1'b1, 32);
        check_frames("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
